// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//   Iterative AES-128 round sequencer. The single-round datapath is reused
//   for every round. This block walks it through the initial AddRoundKey,
//   NUM_ROUNDS-1 full rounds and the final round without MixColumns. It then
//   raises a one-cycle done pulse while the ciphertext sits in the state
//   register.
//
// Optional build macro:
//   AES_CTRL_ABORT_EN - adds the 'abort' input. An abort while busy drops the
//                       block and returns to IDLE without a done pulse.
//
// Parameters:
//   NUM_ROUNDS - full rounds after the initial AddRoundKey (2..15)
//   ROUND_W    - width of the round index (2**ROUND_W > NUM_ROUNDS)
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   start request, accepted only when ready=1
//   abort      in   (AES_CTRL_ABORT_EN only) cancel the block in progress
//   ready      out  start can be accepted this cycle (IDLE, DONE)
//   busy       out  encryption in progress (INIT, ROUND, FINAL)
//   done       out  one-cycle pulse, ciphertext valid in the state register
//   state_sel  out  state mux select: 0 plaintext, 1 round feedback
//   state_en   out  state register load enable
//   key_sel    out  key mux select: 0 cipher key, 1 expanded-key feedback
//   key_en     out  round-key register load enable
//   round      out  current round index 0..NUM_ROUNDS
//   rcon       out  round constant for the current round's key expansion
//   skip_mix   out  bypass MixColumns (final round)
//   init_round out  round 0: AddRoundKey only
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int ROUND_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef AES_CTRL_ABORT_EN
    input  logic               abort,
`endif
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               state_sel,
    output logic               state_en,
    output logic               key_sel,
    output logic               key_en,
    output logic [ROUND_W-1:0] round,
    output logic [7:0]         rcon,
    output logic               skip_mix,
    output logic               init_round
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_e;

    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [ROUND_W-1:0] ROUND_FULL = ROUND_W'(NUM_ROUNDS);

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [7:0]         rcon_q,  rcon_d;

    // GF(2^8) multiply by x, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            round_q <= '0;
            rcon_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        round_d    = '0;
        rcon_d     = 8'h00;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        state_sel  = 1'b0;
        state_en   = 1'b0;
        key_sel    = 1'b0;
        key_en     = 1'b0;
        skip_mix   = 1'b0;
        init_round = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                busy       = 1'b1;
                state_en   = 1'b1;
                key_en     = 1'b1;
                init_round = 1'b1;
                state_d    = (NUM_ROUNDS > 1) ? S_ROUND : S_FINAL;
            end
            S_ROUND: begin
                busy      = 1'b1;
                state_sel = 1'b1;
                key_sel   = 1'b1;
                state_en  = 1'b1;
                key_en    = 1'b1;
                state_d   = (round_q == ROUND_LAST) ? S_FINAL : S_ROUND;
            end
            S_FINAL: begin
                busy      = 1'b1;
                state_sel = 1'b1;
                key_sel   = 1'b1;
                state_en  = 1'b1;
                key_en    = 1'b1;
                skip_mix  = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                ready   = 1'b1;
                done    = 1'b1;
                // A start here chains straight into the next block.
                state_d = start ? S_INIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef AES_CTRL_ABORT_EN
        if (abort && busy) state_d = S_IDLE;
`endif

        // Round index and Rcon follow the state being entered, so both are
        // plain registers aligned with the FSM.
        case (state_d)
            S_ROUND: begin
                round_d = (state_q == S_INIT) ? ROUND_W'(1) : round_q + ROUND_W'(1);
                rcon_d  = (state_q == S_INIT) ? 8'h01 : xtime(rcon_q);
            end
            S_FINAL: begin
                round_d = ROUND_FULL;
                rcon_d  = (state_q == S_INIT) ? 8'h01 : xtime(rcon_q);
            end
            S_DONE: begin
                round_d = ROUND_FULL;
                rcon_d  = 8'h00;
            end
            default: begin
                round_d = '0;
                rcon_d  = 8'h00;
            end
        endcase
    end

    assign round = round_q;
    assign rcon  = rcon_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
//   Self-checking bench for aes_round_ctrl. A cycle-position reference model
//   (position in the block: idle, 0 = INIT, 1..NR = rounds, NR+1 = DONE)
//   predicts every output each cycle. Directed scenarios cover reset, single
//   block latency, the Rcon sequence, back-to-back blocks and mid-block
//   reset. A long random run follows. Abort scenarios are built when
//   AES_CTRL_ABORT_EN is defined.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int RW = 4;
`ifdef AES_CTRL_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_s = 1'b1;
    logic          start_s = 1'b0;
    logic          abort_s = 1'b0;
    logic          ready, busy, done, state_sel, state_en, key_sel, key_en;
    logic [RW-1:0] round;
    logic [7:0]    rcon;
    logic          skip_mix, init_round;

    int checks   = 0;
    int failures = 0;
    int pos      = -1;   // -1 idle, 0 INIT, 1..NR rounds, NR+1 DONE
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc[$];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_W(RW)) dut (
        .clk       (clk),
        .reset     (reset_s),
        .start     (start_s),
`ifdef AES_CTRL_ABORT_EN
        .abort     (abort_s),
`endif
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .state_sel (state_sel),
        .state_en  (state_en),
        .key_sel   (key_sel),
        .key_en    (key_en),
        .round     (round),
        .rcon      (rcon),
        .skip_mix  (skip_mix),
        .init_round(init_round)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Rcon of round r: start at 1, doubling in GF(2^8) once per later round.
    function automatic int ref_rcon(input int r);
        int rc;
        if (r < 1 || r > NR) return 0;
        rc = 1;
        for (int i = 1; i < r; i++) begin
            rc = rc * 2;
            if (rc > 255) rc = rc ^ 'h11B;
        end
        return rc;
    endfunction

    task automatic model_step();
        if (reset_s)                       pos = -1;
        else if (pos == -1 || pos == NR+1) pos = start_s ? 0 : -1;
        else if (ABORT_EN && abort_s)      pos = -1;
        else                               pos = pos + 1;
    endtask

    task automatic compare_all();
        bit in_blk;
        int exp_round;
        in_blk    = (pos >= 0 && pos <= NR);
        exp_round = (pos < 0) ? 0 : ((pos > NR) ? NR : pos);
        check_eq("ready",      32'(ready),      32'(!in_blk));
        check_eq("busy",       32'(busy),       32'(in_blk));
        check_eq("done",       32'(done),       32'(pos == NR+1));
        check_eq("state_sel",  32'(state_sel),  32'(pos >= 1 && pos <= NR));
        check_eq("key_sel",    32'(key_sel),    32'(pos >= 1 && pos <= NR));
        check_eq("state_en",   32'(state_en),   32'(in_blk));
        check_eq("key_en",     32'(key_en),     32'(in_blk));
        check_eq("skip_mix",   32'(skip_mix),   32'(pos == NR));
        check_eq("init_round", 32'(init_round), 32'(pos == 0));
        check_eq("round",      32'(round),      32'(exp_round));
        check_eq("rcon",       32'(rcon),       32'(in_blk ? ref_rcon(pos) : 0));
    endtask

    task automatic tick(input logic r, input logic s, input logic a);
        reset_s = r;
        start_s = s;
        abort_s = a;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        @(negedge clk);
    endtask

    // Advance with idle inputs until the DUT shows round r (bounded).
    task automatic run_to_round(input int r);
        int n = 0;
        while (!(busy && round == RW'(r)) && n < 40) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        check_eq("reach_round", 32'(round), 32'(r));
    endtask

    initial begin
        logic [7:0] rcon_tbl [0:10];
        logic [7:0] rcon_seen[$];
        int n, d0;

        rcon_tbl = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                     8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

        @(negedge clk);
        // Reset held 3 cycles, then idle.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);

        // Single block: latency and Rcon sequence.
        d0 = done_cnt;
        tick(1'b0, 1'b1, 1'b0);
        n = 1;
        if (busy) rcon_seen.push_back(rcon);
        while (!done && n < 40) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
            if (busy) rcon_seen.push_back(rcon);
        end
        check_eq("latency", 32'(n), 32'(NR + 2));
        check_eq("single_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("rcon_count", 32'(rcon_seen.size()), 32'd11);
        for (int i = 0; i < rcon_seen.size() && i < 11; i++)
            check_eq($sformatf("rcon_seq%0d", i), 32'(rcon_seen[i]), 32'(rcon_tbl[i]));
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);

        // Back-to-back with start held high.
        done_cyc.delete();
        d0 = done_cnt;
        for (int i = 0; i < 3 * (NR + 2) + 2; i++) tick(1'b0, 1'b1, 1'b0);
        check_eq("b2b_done_cnt", 32'(done_cnt - d0), 32'd3);
        for (int i = 1; i < done_cyc.size(); i++)
            check_eq("b2b_period", 32'(done_cyc[i] - done_cyc[i-1]), 32'(NR + 2));
        tick(1'b0, 1'b0, 1'b0);
        while (busy && n < 80) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        tick(1'b0, 1'b0, 1'b0);

        // Reset mid-block at round 5, then a clean block.
        d0 = done_cnt;
        tick(1'b0, 1'b1, 1'b0);
        run_to_round(5);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("reset_no_done", 32'(done_cnt - d0), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        n = 1;
        while (!done && n < 40) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        check_eq("post_reset_latency", 32'(n), 32'(NR + 2));

`ifdef AES_CTRL_ABORT_EN
        // Abort at round 3, then start+abort together in DONE.
        tick(1'b0, 1'b0, 1'b0);
        d0 = done_cnt;
        tick(1'b0, 1'b1, 1'b0);
        run_to_round(3);
        tick(1'b0, 1'b1, 1'b1);
        check_eq("abort_idle", 32'(ready && !busy && round == 0), 32'd1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        n = 1;
        while (!done && n < 40) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        tick(1'b0, 1'b1, 1'b1);
        check_eq("abort_in_done_init", 32'(init_round), 32'd1);
        for (int i = 0; i < NR + 3; i++) tick(1'b0, 1'b0, 1'b0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++)
            tick(($urandom_range(63) == 0),
                 ($urandom_range(2) == 0),
                 ($urandom_range(31) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 round sequencer for the optimised datapath.
- Drives the 2:1 state and key multiplexer selects (0 = fresh input, 1 = feedback), the register load enables, the round index, Rcon and the final-round MixColumns bypass.
- Sits between the host start/done handshake and the single-round datapath, which is reused for every round.

Parameters:
- NUM_ROUNDS, 10, number of full rounds after the initial AddRoundKey; legal range 2..15.
- ROUND_W, 4, width of the round index; must satisfy 2^ROUND_W > NUM_ROUNDS.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- start  input  1  request to encrypt the block currently present on the datapath inputs.
- ready  output  1  controller can accept start this cycle.
- busy  output  1  encryption in progress.
- done  output  1  one-cycle pulse; ciphertext valid in the state register.
- state_sel  output  1  state mux select: 0 = plaintext input, 1 = round feedback.
- state_en  output  1  state register load enable.
- key_sel  output  1  key mux select: 0 = cipher key input, 1 = expanded-key feedback.
- key_en  output  1  round-key register load enable.
- round  output  ROUND_W  current round index, 0..NUM_ROUNDS.
- rcon  output  8  round constant for the key expansion step of the current round.
- skip_mix  output  1  bypass MixColumns (final round).
- init_round  output  1  round 0: AddRoundKey only, with SubBytes/ShiftRows/MixColumns bypassed.

Behaviour:
- Reset values: FSM=IDLE, round=0, rcon=0x00, ready=1, and busy, done, state_sel, state_en, key_sel, key_en, skip_mix, init_round all 0.
- FSM states are IDLE, INIT, ROUND, FINAL, DONE. All outputs are registered or decoded only from FSM/round; there are no combinational paths from start.
- IDLE:
  - ready=1, busy=0.
  - start=1 leads to INIT next cycle.
- INIT (1 cycle):
  - state_sel=0, key_sel=0, state_en=1, key_en=1, init_round=1, round=0, rcon=0x00.
  - Next state is ROUND if NUM_ROUNDS>1, otherwise FINAL.
- ROUND (NUM_ROUNDS-1 cycles):
  - state_sel=1, key_sel=1, state_en=1, key_en=1, skip_mix=0.
  - round runs 1..NUM_ROUNDS-1 and increments each cycle.
  - When round==NUM_ROUNDS-1, the next state is FINAL.
- FINAL (1 cycle):
  - As ROUND, but skip_mix=1 and round=NUM_ROUNDS.
  - Next state is DONE.
- DONE (1 cycle):
  - done=1, state_en=0, key_en=0, ready=1, busy=0.
  - round holds NUM_ROUNDS.
  - start=1 in DONE leads to INIT next cycle (back-to-back blocks, no idle gap); otherwise IDLE.
- busy=1 in INIT, ROUND and FINAL.
- ready=1 only in IDLE and DONE. start is ignored in every other state.
- Latency: start sampled at edge T gives INIT at T+1, FINAL at T+NUM_ROUNDS+1 and done at T+NUM_ROUNDS+2 (12 cycles for the default).
- rcon:
  - 0x01 in round 1.
  - Each subsequent round becomes xtime(previous): shift left 1; if the old bit 7 was set, XOR with 0x1B.
  - Sequence for the default: 01,02,04,08,10,20,40,80,1B,36.
  - rcon is 0x00 in IDLE, INIT and DONE.
- Selects and enables are 0 in IDLE and DONE, so the state register holds the ciphertext until the next INIT.
- Reset asserted in any state returns every output to its reset value on the next edge. A partial block is discarded and no done pulse is issued.
- start and reset both high: reset wins.

Optional Feature:
- Macro: AES_CTRL_ABORT_EN.
- When defined:
  - Extra port: abort  input  1.
  - abort=1 in INIT, ROUND or FINAL forces IDLE on the next edge, with round=0, rcon=0x00, all enables 0 and no done pulse.
  - abort in IDLE or DONE has no effect.
  - abort and start both high in DONE: abort has no effect, so the start is accepted.
- When undefined: the port is absent and no abort logic is present. Behaviour is otherwise identical.

Test Plan:
- Reset then idle: hold reset 3 cycles, release → ready=1, busy=0, round=0, rcon=0x00; all enables 0 for 5 idle cycles.
- Single block, default: start pulse at cycle 0 → INIT at cycle 1 (state_sel=0, init_round=1), rounds 1..9 at cycles 2..10, FINAL at cycle 11 (skip_mix=1, round=10, rcon=0x36), done=1 exactly at cycle 12.
- Rcon check: record rcon in each busy cycle → 00,01,02,04,08,10,20,40,80,1B,36.
- Back-to-back: start held high continuously → done pulses every 12 cycles; INIT immediately follows each DONE; start is ignored while busy.
- Reset mid-operation: reset at round 5 → next cycle matches the reset state; no done pulse; a new start 2 cycles later completes normally in 12 cycles.
- With AES_CTRL_ABORT_EN: abort at round 3 → IDLE next cycle, no done pulse. A second run where abort and start are both high in DONE → start accepted, INIT follows.
